// File: rtl/riscv_pipe_skid_stage_pkg.sv
`default_nettype none
// ============================================================
// riscv_pipe_skid_stage_pkg : shared width and state encodings
// Rev 1.0
// ============================================================
package riscv_pipe_skid_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_sat_counter.sv
`default_nettype none
// ============================================================
// riscv_sat_counter : saturating event counter, cleared by reset
// Rev 1.0
// ============================================================
module riscv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Hold at all-ones instead of wrapping
    if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/riscv_pipe_skid_stage.sv
`default_nettype none
// ============================================================
// riscv_pipe_skid_stage : elastic stage register, 2-entry skid
// Rev 1.0
// ============================================================
module riscv_pipe_skid_stage
  import riscv_pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W        = XLEN,
  parameter logic [DATA_W-1:0] REGISTER_INIT = '0,
  parameter int                CNT_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              w_in_xfer;
  logic              w_out_xfer;

  // Handshake outputs decode straight from the state flop
  assign o_valid     = (state_q == SKID_BUSY) || (state_q == SKID_FULL);
  assign o_ready     = (state_q == SKID_EMPTY) || (state_q == SKID_BUSY);
  assign o_occupancy = (state_q == SKID_FULL) ? 2'd2 :
                       (state_q == SKID_BUSY) ? 2'd1 : 2'd0;
  assign o_data      = main_q;

  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = SKID_EMPTY;
      main_d  = REGISTER_INIT;
      skid_d  = REGISTER_INIT;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (w_in_xfer) begin
            state_d = SKID_BUSY;
            main_d  = i_data;
          end
        end
        SKID_BUSY: begin
          case ({w_in_xfer, w_out_xfer})
            2'b11:   main_d = i_data;
            2'b10: begin
              state_d = SKID_FULL;
              skid_d  = i_data;
            end
            2'b01:   state_d = SKID_EMPTY;
            default: state_d = SKID_BUSY;
          endcase
        end
        SKID_FULL: begin
          if (w_out_xfer) begin
            state_d = SKID_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= SKID_EMPTY;
      main_q  <= REGISTER_INIT;
      skid_q  <= REGISTER_INIT;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  riscv_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_inc  (o_valid & ~i_ready),
    .o_cnt  (o_stall_cnt)
  );

endmodule
`default_nettype wire
